// File: rtl/seg7_scan_controller.sv
// Time-multiplexed hex driver for NUM_DIGITS 7-segment digits, with a shadow buffer committed at frame wrap.
// Latency: pins are registered, 1 cycle after an index change or commit.
// Backpressure: none; writes are always accepted, and the last write before the wrap tick wins.
`default_nettype none

module seg7_scan_controller #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      wr_en,
    input  logic [4*NUM_DIGITS-1:0]   wr_data,
    input  logic [NUM_DIGITS-1:0]     wr_dp,
    input  logic [NUM_DIGITS-1:0]     wr_blank,
    input  logic                      lz_suppress,
    output logic [6:0]                seg_out,
    output logic                      dp_out,
    output logic [NUM_DIGITS-1:0]     an_out,
    output logic                      frame_tick,
    output logic                      pending
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = {7{SEG_ACTIVE_LOW}};
    localparam logic DP_OFF = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF = {NUM_DIGITS{AN_ACTIVE_LOW}};

    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0]   sh_data_q, sh_data_d;
    logic [NUM_DIGITS-1:0]     sh_dp_q, sh_dp_d;
    logic [NUM_DIGITS-1:0]     sh_blank_q, sh_blank_d;
    logic                      pending_q, pending_d;
    logic [4*NUM_DIGITS-1:0]   disp_data_q, disp_data_d;
    logic [NUM_DIGITS-1:0]     disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0]     disp_blank_q, disp_blank_d;
    logic                      frame_tick_q, frame_tick_d;
    logic [6:0]                seg_q, seg_d;
    logic                      dp_q, dp_d;
    logic [NUM_DIGITS-1:0]     an_q, an_d;

    logic                      tick;
    logic                      wrap;
    logic [NUM_DIGITS-1:0]     supp;
    logic [NUM_DIGITS-1:0]     an_hot;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_blank;
    logic                      cur_supp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'b0111111;
            4'h1: s = 7'b0000110;
            4'h2: s = 7'b1011011;
            4'h3: s = 7'b1001111;
            4'h4: s = 7'b1100110;
            4'h5: s = 7'b1101101;
            4'h6: s = 7'b1111101;
            4'h7: s = 7'b0000111;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1101111;
            4'hA: s = 7'b1110111;
            4'hB: s = 7'b1111100;
            4'hC: s = 7'b0111001;
            4'hD: s = 7'b1011110;
            4'hE: s = 7'b1111001;
            default: s = 7'b1110001;
        endcase
        return s;
    endfunction

    assign tick = (cnt_q == CNT_MAX);
    assign wrap = tick && (idx_q == IDX_MAX);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) begin
            idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
        end
        frame_tick_d = wrap;
    end

    // A write landing on the wrap tick bypasses the shadow so it is not delayed a whole frame.
    always_comb begin
        sh_data_d    = sh_data_q;
        sh_dp_d      = sh_dp_q;
        sh_blank_d   = sh_blank_q;
        pending_d    = pending_q;
        disp_data_d  = disp_data_q;
        disp_dp_d    = disp_dp_q;
        disp_blank_d = disp_blank_q;
        if (wr_en) begin
            sh_data_d  = wr_data;
            sh_dp_d    = wr_dp;
            sh_blank_d = wr_blank;
        end
        if (wrap) begin
            pending_d = 1'b0;
            if (wr_en) begin
                disp_data_d  = wr_data;
                disp_dp_d    = wr_dp;
                disp_blank_d = wr_blank;
            end else if (pending_q) begin
                disp_data_d  = sh_data_q;
                disp_dp_d    = sh_dp_q;
                disp_blank_d = sh_blank_q;
            end
        end else if (wr_en) begin
            pending_d = 1'b1;
        end
    end

    // Walk from the most significant digit down; a digit is suppressed while everything above it is zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        supp       = '0;
        an_hot     = '0;
        cur_nib    = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_supp   = 1'b0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (disp_data_q[4*i +: 4] == 4'h0);
            supp[i]    = lz_suppress & zero_above & (i != 0);
            if (IW'(i) == idx_q) begin
                an_hot[i] = 1'b1;
                cur_nib   = disp_data_q[4*i +: 4];
                cur_dp    = disp_dp_q[i];
                cur_blank = disp_blank_q[i];
                cur_supp  = supp[i];
            end
        end
    end

    always_comb begin
        logic [6:0]            seg_act;
        logic                  dp_act;
        logic [NUM_DIGITS-1:0] an_act;
        seg_act = '0;
        dp_act  = 1'b0;
        an_act  = '0;
        if (!cur_blank) begin
            an_act  = an_hot;
            dp_act  = cur_dp;
            seg_act = cur_supp ? 7'b0 : hex_to_seg(cur_nib);
        end
        seg_d = seg_act ^ SEG_OFF;
        dp_d  = dp_act ^ DP_OFF;
        an_d  = an_act ^ AN_OFF;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            sh_data_q    <= '0;
            sh_dp_q      <= '0;
            sh_blank_q   <= '0;
            pending_q    <= 1'b0;
            disp_data_q  <= '0;
            disp_dp_q    <= '0;
            disp_blank_q <= '0;
            frame_tick_q <= 1'b0;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            an_q         <= AN_OFF;
        end else begin
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            sh_data_q    <= sh_data_d;
            sh_dp_q      <= sh_dp_d;
            sh_blank_q   <= sh_blank_d;
            pending_q    <= pending_d;
            disp_data_q  <= disp_data_d;
            disp_dp_q    <= disp_dp_d;
            disp_blank_q <= disp_blank_d;
            frame_tick_q <= frame_tick_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            an_q         <= an_d;
        end
    end

    assign seg_out    = seg_q;
    assign dp_out     = dp_q;
    assign an_out     = an_q;
    assign frame_tick = frame_tick_q;
    assign pending    = pending_q;

endmodule

`default_nettype wire
